uart_receiver: RTL

//  Oversampling UART receive stage; consumer of the timer_input baud tick (done), which is wired to s_tick.
//  - timer_input is programmed for 16 ticks per bit, e.g. FINAL_VALUE=650 at 100 MHz / 9600 baud.
//  - Synchronises the serial rx line, detects and qualifies the start bit, and samples data mid-bit (LSB first).
//  - Checks optional parity and the stop bit.
//  - Presents each received byte with a one-cycle strobe to the downstream FIFO / interface logic.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_sync2.sv | 25 ++
 rtl/uart_receiver.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: FSM state encodings and
// oversampling positions within one bit period.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for asynchronous serial-side inputs; resets to 1 so
// an idle-high line does not produce a false edge when reset is released.
module uart_sync2 (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// Oversampling UART receiver: qualifies the start bit, samples data LSB first
// mid-bit, checks optional parity and the stop bit, strobes each word out.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = 8,
  parameter int unsigned SB_TICK    = 16,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);

  localparam logic [4:0] MID_CNT  = 5'(MID_SAMPLE);
  localparam logic [4:0] LAST_CNT = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_CNT = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);
  localparam logic       PAR_ODD  = 1'(PARITY_ODD);
  localparam logic       PAR_USE  = (PARITY_EN != 0);

  logic            rx_s;
  logic [2:0]      state_q, state_d;
  logic [4:0]      s_cnt_q, s_cnt_d;
  logic [2:0]      n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_bad_q, par_bad_d;
  logic            stop_q, stop_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            done_q, done_d;
  logic            stop_now;

  uart_sync2 u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (rx),
    .q_o     (rx_s)
  );

  // STOP is entered at the centre of the last data/parity bit, so the stop
  // bit's centre is a full bit period later, at s_cnt == OVERSAMPLE-1.
  assign stop_now = (s_cnt_q == LAST_CNT) ? rx_s : stop_q;

  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    b_d       = b_q;
    par_bad_d = par_bad_q;
    stop_d    = stop_q;
    dout_d    = dout_q;
    ferr_d    = ferr_q;
    perr_d    = perr_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (s_tick) begin
          if (s_cnt_q == MID_CNT) begin
            if (!rx_s) begin
              state_d   = DATA;
              s_cnt_d   = '0;
              n_cnt_d   = '0;
              par_bad_d = 1'b0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_CNT) begin
            s_cnt_d = '0;
            b_d     = {rx_s, b_q[DBIT-1:1]};
            if (n_cnt_q == LAST_BIT) begin
              state_d = PAR_USE ? PARITY : STOP;
            end else begin
              n_cnt_d = n_cnt_q + 3'd1;
            end
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      PARITY: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_CNT) begin
            par_bad_d = (^{b_q, rx_s}) ^ PAR_ODD;
            state_d   = STOP;
            s_cnt_d   = '0;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == LAST_CNT) begin
            stop_d = rx_s;
          end
          if (s_cnt_q == STOP_CNT) begin
            state_d = IDLE;
            done_d  = 1'b1;
            dout_d  = b_q;
            ferr_d  = ~stop_now;
            perr_d  = PAR_USE & par_bad_q;
          end else begin
            s_cnt_d = s_cnt_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      b_q       <= '0;
      par_bad_q <= 1'b0;
      stop_q    <= 1'b0;
      dout_q    <= '0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      b_q       <= b_d;
      par_bad_q <= par_bad_d;
      stop_q    <= stop_d;
      dout_q    <= dout_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      done_q    <= done_d;
    end
  end

  assign rx_dout      = dout_q;
  assign rx_done_tick = done_q;
  assign frame_err    = ferr_q;
  assign parity_err   = perr_q;

endmodule
